// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller: op encodings, FSM states and
// register-file geometry.
package alu_pkg;

    localparam int WORD_W   = 8;
    localparam int OP_W     = 5;
    localparam int NUM_REGS = 4;
    localparam int REG_AW   = $clog2(NUM_REGS);
    localparam int INSTR_W  = OP_W + 2 * REG_AW;

    localparam logic [OP_W-1:0] OP_AND = 5'b00000;
    localparam logic [OP_W-1:0] OP_OR  = 5'b00001;
    localparam logic [OP_W-1:0] OP_NOT = 5'b00010;
    localparam logic [OP_W-1:0] OP_XOR = 5'b00011;
    localparam logic [OP_W-1:0] OP_ADD = 5'b00100;
    localparam logic [OP_W-1:0] OP_SUB = 5'b00101;
    localparam logic [OP_W-1:0] OP_EOR = 5'b00110;
    localparam logic [OP_W-1:0] OP_LSL = 5'b10000;
    localparam logic [OP_W-1:0] OP_LSR = 5'b10001;
    localparam logic [OP_W-1:0] OP_CMP = 5'b11000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_OR, OP_NOT, OP_XOR, OP_ADD,
            OP_SUB, OP_EOR, OP_LSL, OP_LSR, OP_CMP: op_is_legal = 1'b1;
            default:                                op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: unsigned wrap-around arithmetic, logic ops, shifts by the
// full operand B, and unsigned compare flags.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] y,
    output logic              equal,
    output logic              less,
    output logic              legal
);

    localparam int SH_W = $clog2(DATA_W);

    logic              shift_overflow;
    logic [SH_W-1:0]   shamt;

    // Any set bit above the in-range shift field pushes every bit out.
    assign shift_overflow = |b[DATA_W-1:SH_W];
    assign shamt          = b[SH_W-1:0];

    function automatic logic [DATA_W-1:0] zext1(input logic bit_in);
        zext1 = {{(DATA_W-1){1'b0}}, bit_in};
    endfunction

    always_comb begin
        y     = '0;
        legal = op_is_legal(op);
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = zext1(~|a);
            OP_EOR: y = zext1(^a);
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_CMP: y = a - b;
            OP_LSL: y = shift_overflow ? '0 : (a << shamt);
            OP_LSR: y = shift_overflow ? '0 : (a >> shamt);
            default: y = '0;
        endcase
    end

    assign equal = (a == b);
    assign less  = (a < b);

endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle ALU controller: 4-entry register file, IDLE/READ/EXEC/WB
// sequencer and registered result, flags and completion pulses.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [INSTR_W-1:0]  instr,
    output logic                instr_ready,
    input  logic                reg_wr_en,
    input  logic [REG_AW-1:0]   reg_wr_addr,
    input  logic [DATA_W-1:0]   reg_wr_data,
    input  logic [REG_AW-1:0]   dbg_rd_addr,
    output logic [DATA_W-1:0]   dbg_rd_data,
    output logic [DATA_W-1:0]   result,
    output logic                equal_flag,
    output logic                less_flag,
    output logic                done,
    output logic                illegal
);

    state_t              state;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic [OP_W-1:0]     op_p0;
    logic [REG_AW-1:0]   ra_p0;
    logic [REG_AW-1:0]   rb_p0;
    logic [DATA_W-1:0]   opa_p1;
    logic [DATA_W-1:0]   opb_p1;
    logic                legal_p2;

    logic [DATA_W-1:0]   alu_y;
    logic                alu_equal;
    logic                alu_less;
    logic                alu_legal;
    logic                accept;

    assign instr_ready = (state == ST_IDLE);
    assign accept      = instr_valid && instr_ready;
    assign dbg_rd_data = regs[dbg_rd_addr];

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a     (opa_p1),
        .b     (opb_p1),
        .op    (op_p0),
        .y     (alu_y),
        .equal (alu_equal),
        .less  (alu_less),
        .legal (alu_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            result     <= '0;
            equal_flag <= 1'b0;
            less_flag  <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                // p0: external load and instruction capture share the IDLE edge
                ST_IDLE: begin
                    if (reg_wr_en) begin
                        regs[reg_wr_addr] <= reg_wr_data;
                    end
                    if (accept) begin
                        op_p0 <= instr[INSTR_W-1 -: OP_W];
                        ra_p0 <= instr[2*REG_AW-1 -: REG_AW];
                        rb_p0 <= instr[REG_AW-1:0];
                        state <= ST_READ;
                    end
                end
                // p1: operand fetch
                ST_READ: begin
                    opa_p1 <= regs[ra_p0];
                    opb_p1 <= regs[rb_p0];
                    state  <= ST_EXEC;
                end
                // p2: execute; illegal ops leave result and flags untouched
                ST_EXEC: begin
                    legal_p2 <= alu_legal;
                    if (alu_legal) begin
                        result     <= alu_y;
                        equal_flag <= alu_equal;
                        less_flag  <= alu_less;
                    end
                    state <= ST_WB;
                end
                // p3: writeback and completion pulse land on the same edge
                ST_WB: begin
                    if (legal_p2 && (op_p0 != OP_CMP)) begin
                        regs[ra_p0] <= result;
                    end
                    done    <= legal_p2;
                    illegal <= ~legal_p2;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
